// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - dual-port (ibus/dbus) latency-programmable memory responder
module mem_responder #(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
);

    localparam int          AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT      = 4'(LATENCY - 1);
    localparam logic [63:0] LIMIT         = 64'(DEPTH) << 3;
    localparam logic        FIRE_ON_ENTRY = (LATENCY == 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Shared storage; deliberately not cleared by reset.
    logic [63:0] mem [DEPTH];

    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
        return AW'((a - BASE) >> 3);
    endfunction

    // Outputs are registered, so a port "fires" one cycle before data_ok is
    // visible: the edge that launches data_ok is also the write-commit edge
    // and the edge at which reads sample the array.

    state_t        i_state_q, i_state_d;
    logic [3:0]    i_cnt_q, i_cnt_d;
    logic [63:0]   i_addr_q, i_addr_d;
    logic          i_fire;
    logic          i_ok_q, i_ok_d;
    logic [31:0]   i_data_q, i_data_d;
    logic [63:0]   i_word;

    state_t        d_state_q, d_state_d;
    logic [3:0]    d_cnt_q, d_cnt_d;
    logic [63:0]   d_addr_q, d_addr_d;
    logic [7:0]    d_strobe_q, d_strobe_d;
    logic [63:0]   d_wdata_q, d_wdata_d;
    logic          d_fire;
    logic          d_changed;
    logic          d_hit;
    logic          d_we;
    logic          d_ok_q, d_ok_d;
    logic [63:0]   d_data_q, d_data_d;
    logic [63:0]   d_word;
    logic [63:0]   d_merged;

    logic          unused_bits;
    assign unused_bits = ^{dreq_size, ireq_addr[1:0]};

    // ibus FSM: accept, count down, restart on address change, abort on drop.
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        i_fire    = 1'b0;
        unique case (i_state_q)
            S_IDLE: begin
                if (ireq_valid) begin
                    i_state_d = S_WAIT;
                    i_cnt_d   = CNT_INIT;
                    i_addr_d  = ireq_addr;
                    i_fire    = FIRE_ON_ENTRY;
                end
            end
            S_WAIT: begin
                if (i_cnt_q == 4'd0) begin
                    i_state_d = S_IDLE;
                end else if (!ireq_valid) begin
                    i_state_d = S_IDLE;
                    i_cnt_d   = 4'd0;
                end else if (ireq_addr != i_addr_q) begin
                    i_cnt_d  = CNT_INIT;
                    i_addr_d = ireq_addr;
                    i_fire   = FIRE_ON_ENTRY;
                end else begin
                    i_cnt_d = i_cnt_q - 4'd1;
                    i_fire  = (i_cnt_q == 4'd1);
                end
            end
            default: i_state_d = S_IDLE;
        endcase
    end

    // ibus response: 32-bit half selected by addr[2], zero when out of range.
    always_comb begin
        i_word   = mem[word_idx(ireq_addr)];
        i_ok_d   = i_fire;
        i_data_d = '0;
        if (i_fire && in_range(ireq_addr)) begin
            i_data_d = ireq_addr[2] ? i_word[63:32] : i_word[31:0];
        end
    end

    // dbus FSM: same protocol, but strobe and data changes also restart.
    always_comb begin
        d_state_d  = d_state_q;
        d_cnt_d    = d_cnt_q;
        d_addr_d   = d_addr_q;
        d_strobe_d = d_strobe_q;
        d_wdata_d  = d_wdata_q;
        d_fire     = 1'b0;
        d_changed  = (dreq_addr != d_addr_q) || (dreq_strobe != d_strobe_q) ||
                     (dreq_data != d_wdata_q);
        unique case (d_state_q)
            S_IDLE: begin
                if (dreq_valid) begin
                    d_state_d  = S_WAIT;
                    d_cnt_d    = CNT_INIT;
                    d_addr_d   = dreq_addr;
                    d_strobe_d = dreq_strobe;
                    d_wdata_d  = dreq_data;
                    d_fire     = FIRE_ON_ENTRY;
                end
            end
            S_WAIT: begin
                if (d_cnt_q == 4'd0) begin
                    d_state_d = S_IDLE;
                end else if (!dreq_valid) begin
                    d_state_d = S_IDLE;
                    d_cnt_d   = 4'd0;
                end else if (d_changed) begin
                    d_cnt_d    = CNT_INIT;
                    d_addr_d   = dreq_addr;
                    d_strobe_d = dreq_strobe;
                    d_wdata_d  = dreq_data;
                    d_fire     = FIRE_ON_ENTRY;
                end else begin
                    d_cnt_d = d_cnt_q - 4'd1;
                    d_fire  = (d_cnt_q == 4'd1);
                end
            end
            default: d_state_d = S_IDLE;
        endcase
    end

    // dbus datapath: byte-merge for writes; response is the post-write word.
    always_comb begin
        d_hit  = in_range(dreq_addr);
        d_word = mem[word_idx(dreq_addr)];
        for (int b = 0; b < 8; b++) begin
            d_merged[8*b +: 8] = dreq_strobe[b] ? dreq_data[8*b +: 8] : d_word[8*b +: 8];
        end
        d_we     = d_fire && d_hit && (dreq_strobe != 8'h00) && !reset;
        d_ok_d   = d_fire;
        d_data_d = (d_fire && d_hit) ? d_merged : 64'h0;
    end

    // State, latched requests and registered responses; reset cancels all.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_state_q  <= S_IDLE;
            i_cnt_q    <= 4'd0;
            i_addr_q   <= 64'h0;
            i_ok_q     <= 1'b0;
            i_data_q   <= 32'h0;
            d_state_q  <= S_IDLE;
            d_cnt_q    <= 4'd0;
            d_addr_q   <= 64'h0;
            d_strobe_q <= 8'h0;
            d_wdata_q  <= 64'h0;
            d_ok_q     <= 1'b0;
            d_data_q   <= 64'h0;
        end else begin
            i_state_q  <= i_state_d;
            i_cnt_q    <= i_cnt_d;
            i_addr_q   <= i_addr_d;
            i_ok_q     <= i_ok_d;
            i_data_q   <= i_data_d;
            d_state_q  <= d_state_d;
            d_cnt_q    <= d_cnt_d;
            d_addr_q   <= d_addr_d;
            d_strobe_q <= d_strobe_d;
            d_wdata_q  <= d_wdata_d;
            d_ok_q     <= d_ok_d;
            d_data_q   <= d_data_d;
        end
    end

    // Array write port; ibus reads above see the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (d_we) begin
            mem[word_idx(dreq_addr)] <= d_merged;
        end
    end

    assign iresp_addr_ok = i_ok_q;
    assign iresp_data_ok = i_ok_q;
    assign iresp_data    = i_data_q;
    assign dresp_addr_ok = d_ok_q;
    assign dresp_data_ok = d_ok_q;
    assign dresp_data    = d_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 32;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    int checks   = 0;
    int failures = 0;

    logic [63:0] ref_mem [DEPTH];

    mem_responder #(.LATENCY(LAT), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic logic [63:0] m_iread(input logic [63:0] a);
        logic [63:0] w;
        if (!m_in(a)) return 64'h0;
        w = ref_mem[m_idx(a)];
        return (((a - BASE) % 8) >= 4) ? (w >> 32) : (w & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [63:0] m_dacc(input logic [63:0] a, input logic [7:0] s,
                                           input logic [63:0] d);
        logic [63:0] mask;
        logic [63:0] w;
        if (!m_in(a)) return 64'h0;
        mask = 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) mask = mask | (64'hFF << (8 * b));
        w = (ref_mem[m_idx(a)] & ~mask) | (d & mask);
        ref_mem[m_idx(a)] = w;
        return w;
    endfunction

    function automatic logic [63:0] rand_addr(input bit ibus);
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1)
                return BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 15)) * 8;
            return 64'($urandom_range(0, 4095)) * 8;
        end
        return BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 +
               (ibus ? 64'($urandom_range(0, 1)) * 4 : 64'h0);
    endfunction

    // Launch one request on either or both ports from IDLE and check both
    // responses arrive exactly LAT cycles later with the model's data.
    task automatic do_pair(input bit ien, input logic [63:0] ia,
                           input bit den, input logic [63:0] da, input logic [7:0] ds,
                           input logic [63:0] dd, input string tag,
                           output logic [63:0] iobs, output logic [63:0] dobs);
        logic [63:0] i_exp;
        logic [63:0] d_exp;
        int ki;
        int kd;
        bit idone;
        bit ddone;
        i_exp = m_iread(ia);
        d_exp = den ? m_dacc(da, ds, dd) : 64'h0;
        iobs = 64'h0;
        dobs = 64'h0;
        @(negedge clk);
        ireq_valid  = ien;
        ireq_addr   = ia;
        dreq_valid  = den;
        dreq_addr   = da;
        dreq_strobe = ds;
        dreq_data   = dd;
        dreq_size   = 3'($urandom_range(0, 7));
        ki = 0;
        kd = 0;
        idone = !ien;
        ddone = !den;
        for (int k = 1; k <= 20 && !(idone && ddone); k++) begin
            @(negedge clk);
            if (!idone && iresp_data_ok) begin
                ki = k;
                idone = 1'b1;
                iobs = 64'(iresp_data);
                check({tag, "_i_data"}, iobs, i_exp);
                check({tag, "_i_addr_ok"}, 64'(iresp_addr_ok), 64'h1);
                ireq_valid = 1'b0;
            end
            if (!ddone && dresp_data_ok) begin
                kd = k;
                ddone = 1'b1;
                dobs = dresp_data;
                check({tag, "_d_data"}, dobs, d_exp);
                check({tag, "_d_addr_ok"}, 64'(dresp_addr_ok), 64'h1);
                dreq_valid = 1'b0;
            end
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        if (ien) check({tag, "_i_latency"}, 64'(ki), 64'(LAT));
        if (den) check({tag, "_d_latency"}, 64'(kd), 64'(LAT));
    endtask

    initial begin
        logic [63:0] io;
        logic [63:0] dob;
        logic [63:0] oldw;
        logic [63:0] ia;
        logic [63:0] da;
        logic [7:0]  ds;
        int          k;
        int          op;
        bit          seen;

        reset = 1'b1;
        ireq_valid = 1'b0; ireq_addr = 64'h0;
        dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0;
        dreq_strobe = 8'h0; dreq_data = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_i_data_ok", 64'(iresp_data_ok), 64'h0);
        check("rst_i_addr_ok", 64'(iresp_addr_ok), 64'h0);
        check("rst_i_data", 64'(iresp_data), 64'h0);
        check("rst_d_data_ok", 64'(dresp_data_ok), 64'h0);
        check("rst_d_addr_ok", 64'(dresp_addr_ok), 64'h0);
        check("rst_d_data", dresp_data, 64'h0);
        reset = 1'b0;

        for (int w = 0; w < DEPTH; w++)
            do_pair(1'b0, 64'h0, 1'b1, BASE + 64'(w) * 8, 8'hFF,
                    {$urandom, $urandom}, "preload", io, dob);

        do_pair(1'b0, 64'h0, 1'b1, BASE, 8'hFF, 64'h1111_2222_3333_4444, "w0", io, dob);
        do_pair(1'b1, BASE, 1'b0, 64'h0, 8'h0, 64'h0, "ilo", io, dob);
        check("ibus_lo_const", io, 64'h3333_4444);
        do_pair(1'b1, BASE + 4, 1'b0, 64'h0, 8'h0, 64'h0, "ihi", io, dob);
        check("ibus_hi_const", io, 64'h1111_2222);

        do_pair(1'b0, 64'h0, 1'b1, BASE + 8, 8'hFF, 64'h0, "clr1", io, dob);
        do_pair(1'b0, 64'h0, 1'b1, BASE + 8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, "strb", io, dob);
        check("strobe_wr_const", dob, 64'h0000_0000_CCCC_DDDD);
        do_pair(1'b0, 64'h0, 1'b1, BASE + 8, 8'h00, 64'h0, "strb_rd", io, dob);
        check("strobe_rd_const", dob, 64'h0000_0000_CCCC_DDDD);

        oldw = ref_mem[2];
        do_pair(1'b1, BASE + 16, 1'b1, BASE + 16, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, "coll", io, dob);
        check("coll_old_const", io, oldw & 64'hFFFF_FFFF);
        do_pair(1'b1, BASE + 16, 1'b0, 64'h0, 8'h0, 64'h0, "coll2", io, dob);
        check("coll_new_const", io, 64'h0BAD_F00D);

        oldw = ref_mem[5];
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = BASE + 40; dreq_strobe = 8'hFF; dreq_data = ~oldw;
        @(negedge clk);
        seen = dresp_data_ok;
        dreq_valid = 1'b0;
        repeat (2 * LAT + 2) begin
            @(negedge clk);
            seen = seen | dresp_data_ok;
        end
        check("abort_no_resp", 64'(seen), 64'h0);
        do_pair(1'b0, 64'h0, 1'b1, BASE + 40, 8'h00, 64'h0, "abort_rd", io, dob);
        check("abort_mem_kept", dob, oldw);

        do_pair(1'b1, 64'h1000, 1'b1, 64'h1000, 8'h00, 64'h0, "oor", io, dob);
        check("oor_d_zero", dob, 64'h0);
        do_pair(1'b1, BASE + 64'(DEPTH) * 8, 1'b1, BASE - 8, 8'h00, 64'h0, "oor_edge", io, dob);
        do_pair(1'b1, BASE + 64'(DEPTH - 1) * 8 + 4, 1'b1, BASE + 64'(DEPTH - 1) * 8,
                8'h00, 64'h0, "last_word", io, dob);
        do_pair(1'b0, 64'h0, 1'b1, BASE + 64'(DEPTH) * 8, 8'hFF, 64'h5555_5555_5555_5555,
                "oor_wr", io, dob);
        do_pair(1'b0, 64'h0, 1'b1, BASE, 8'h00, 64'h0, "oor_wr_alias", io, dob);

        @(negedge clk);
        dreq_valid = 1'b1; dreq_strobe = 8'h0; dreq_data = 64'h0; dreq_addr = BASE + 80;
        for (int n = 0; n < 3; n++) begin
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                k++;
                if (dresp_data_ok) break;
            end
            check("b2b_gap", 64'(k), (n == 0) ? 64'(LAT) : 64'(LAT + 1));
            check("b2b_data", dresp_data, ref_mem[10 + n]);
            dreq_addr = BASE + 64'(11 + n) * 8;
        end
        dreq_valid = 1'b0;

        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = BASE + 48; dreq_strobe = 8'h0;
        @(negedge clk);
        check("restart_early", 64'(dresp_data_ok), 64'h0);
        dreq_addr = BASE + 56;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (dresp_data_ok) break;
        end
        check("restart_lat", 64'(k), 64'(LAT));
        check("restart_data", dresp_data, ref_mem[7]);
        dreq_valid = 1'b0;

        oldw = ref_mem[8];
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = BASE + 64; dreq_strobe = 8'hFF; dreq_data = ~oldw;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_d_ok", 64'(dresp_data_ok), 64'h0);
        check("rstw_d_data", dresp_data, 64'h0);
        dreq_valid = 1'b0;
        reset = 1'b0;
        do_pair(1'b0, 64'h0, 1'b1, BASE + 64, 8'h00, 64'h0, "rstw_rd", io, dob);
        check("rstw_not_committed", dob, oldw);

        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = BASE + 72; dreq_strobe = 8'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstr_d_ok", 64'(dresp_data_ok), 64'h0);
        reset = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (dresp_data_ok) break;
        end
        check("rstr_lat", 64'(k), 64'(LAT));
        check("rstr_data", dresp_data, ref_mem[9]);
        dreq_valid = 1'b0;

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 3);
            ia = rand_addr(1'b1);
            da = rand_addr(1'b0);
            ds = (op == 0 || $urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (op == 3 && $urandom_range(0, 1) == 1)
                ia = {da[63:3], 3'b000} + 64'($urandom_range(0, 1)) * 4;
            do_pair(op >= 2, ia, op != 2, da, ds, {$urandom, $urandom}, "rand", io, dob);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
